video_timing_gen: RTL

- Parametrised raster timing generator for the HDMI pixel path; supersedes the fixed 720p signal generator.
- Produces hcount, vcount, sync, active-draw, new-frame and frame-count for any CEA-style mode set by parameters.
- Adds a clock-enable and a parametrised delay line on sync/active-draw, so TMDS control timing aligns with the multi-cycle latency of render.
- Sits between the pixel clock wizard and the render/tmds_encoder blocks.

---
 rtl/video_timing_gen_if.sv | 45 ++++
 rtl/video_timing_gen.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen_if.sv
// Raster timing bundle: video_timing_gen drives it as master, render/tmds consumers read it as slave.
// nl_out/line_idx_out exist only when VIDEO_TIMING_GEN_LINE_PULSE_EN is defined.
interface video_timing_gen_if #(
  parameter int HW  = 11,
  parameter int VW  = 10,
  parameter int FCW = 6
);
  logic           en_in;
  logic [HW-1:0]  hcount_out;
  logic [VW-1:0]  vcount_out;
  logic           hs_out;
  logic           vs_out;
  logic           ad_out;
  logic           nf_out;
  logic [FCW-1:0] fc_out;
  logic           hs_d_out;
  logic           vs_d_out;
  logic           ad_d_out;
`ifdef VIDEO_TIMING_GEN_LINE_PULSE_EN
  logic           nl_out;
  logic [VW-1:0]  line_idx_out;

  modport master (
    input  en_in,
    output hcount_out, vcount_out, hs_out, vs_out, ad_out, nf_out, fc_out,
    output hs_d_out, vs_d_out, ad_d_out, nl_out, line_idx_out
  );
  modport slave (
    output en_in,
    input  hcount_out, vcount_out, hs_out, vs_out, ad_out, nf_out, fc_out,
    input  hs_d_out, vs_d_out, ad_d_out, nl_out, line_idx_out
  );
`else
  modport master (
    input  en_in,
    output hcount_out, vcount_out, hs_out, vs_out, ad_out, nf_out, fc_out,
    output hs_d_out, vs_d_out, ad_d_out
  );
  modport slave (
    output en_in,
    input  hcount_out, vcount_out, hs_out, vs_out, ad_out, nf_out, fc_out,
    input  hs_d_out, vs_d_out, ad_d_out
  );
`endif
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised CEA-style raster timing generator with clock enable and a sync/active-draw delay line.
// Optional end-of-active-line pulse (nl_out, line_idx_out) under macro VIDEO_TIMING_GEN_LINE_PULSE_EN.
module video_timing_gen #(
  parameter int ACTIVE_H   = 1280,
  parameter int FP_H       = 110,
  parameter int SYNC_H     = 40,
  parameter int BP_H       = 220,
  parameter int ACTIVE_V   = 720,
  parameter int FP_V       = 5,
  parameter int SYNC_V     = 5,
  parameter int BP_V       = 20,
  parameter int FPS        = 60,
  parameter int SYNC_POL   = 1,
  parameter int PIPE_DELAY = 4
) (
  input  logic               clk_pixel_in,
  input  logic               rst_in,
  video_timing_gen_if.master vid
);
  localparam int TOTAL_H = ACTIVE_H + FP_H + SYNC_H + BP_H;
  localparam int TOTAL_V = ACTIVE_V + FP_V + SYNC_V + BP_V;
  localparam int HW      = $clog2(TOTAL_H);
  localparam int VW      = $clog2(TOTAL_V);
  localparam int FCW     = $clog2(FPS);

  // Compare constants carry one spare bit so no boundary can alias at full counter width.
  localparam logic [HW:0] H_LAST       = (HW+1)'(TOTAL_H - 1);
  localparam logic [HW:0] H_ACT        = (HW+1)'(ACTIVE_H);
  localparam logic [HW:0] H_SYNC_START = (HW+1)'(ACTIVE_H + FP_H);
  localparam logic [HW:0] H_SYNC_END   = (HW+1)'(ACTIVE_H + FP_H + SYNC_H);
  localparam logic [VW:0] V_LAST       = (VW+1)'(TOTAL_V - 1);
  localparam logic [VW:0] V_ACT        = (VW+1)'(ACTIVE_V);
  localparam logic [VW:0] V_SYNC_START = (VW+1)'(ACTIVE_V + FP_V);
  localparam logic [VW:0] V_SYNC_END   = (VW+1)'(ACTIVE_V + FP_V + SYNC_V);
  localparam logic [FCW-1:0] FC_LAST   = FCW'(FPS - 1);
  localparam logic SYNC_ON             = (SYNC_POL != 0);

  generate
    if (ACTIVE_H < 1 || FP_H < 1 || SYNC_H < 1 || BP_H < 1 ||
        ACTIVE_V < 1 || FP_V < 1 || SYNC_V < 1 || BP_V < 1 || FPS < 2) begin : g_bad_params
      $error("video_timing_gen: porch/sync/active widths must be >= 1 and FPS >= 2");
    end
  endgenerate

  logic [HW-1:0]  h_reg, h_next;
  logic [VW-1:0]  v_reg, v_next;
  logic           hs_reg, hs_next;
  logic           vs_reg, vs_next;
  logic           ad_reg, ad_next;
  logic           nf_reg, nf_next;
  logic [FCW-1:0] fc_reg, fc_next;
  logic [HW:0]    hn_ext;
  logic [VW:0]    vn_ext;
  logic           h_wrap, v_wrap;

  // Decodes are evaluated on the next position so each registered flag matches the count it ships with.
  always_comb begin
    h_wrap  = ({1'b0, h_reg} == H_LAST);
    v_wrap  = ({1'b0, v_reg} == V_LAST);
    h_next  = h_wrap ? '0 : h_reg + HW'(1);
    v_next  = v_reg;
    if (h_wrap) begin
      v_next = v_wrap ? '0 : v_reg + VW'(1);
    end
    hn_ext  = {1'b0, h_next};
    vn_ext  = {1'b0, v_next};
    ad_next = (hn_ext < H_ACT) && (vn_ext < V_ACT);
    hs_next = ((hn_ext >= H_SYNC_START) && (hn_ext < H_SYNC_END)) ? SYNC_ON : ~SYNC_ON;
    vs_next = ((vn_ext >= V_SYNC_START) && (vn_ext < V_SYNC_END)) ? SYNC_ON : ~SYNC_ON;
    nf_next = (hn_ext == H_ACT) && (vn_ext == V_ACT);
    fc_next = fc_reg;
    if (nf_next) begin
      fc_next = (fc_reg == FC_LAST) ? '0 : fc_reg + FCW'(1);
    end
  end

  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      h_reg  <= '0;
      v_reg  <= '0;
      hs_reg <= ~SYNC_ON;
      vs_reg <= ~SYNC_ON;
      ad_reg <= 1'b1;
      nf_reg <= 1'b0;
      fc_reg <= '0;
    end else if (vid.en_in) begin
      h_reg  <= h_next;
      v_reg  <= v_next;
      hs_reg <= hs_next;
      vs_reg <= vs_next;
      ad_reg <= ad_next;
      nf_reg <= nf_next;
      fc_reg <= fc_next;
    end
  end

  assign vid.hcount_out = h_reg;
  assign vid.vcount_out = v_reg;
  assign vid.hs_out     = hs_reg;
  assign vid.vs_out     = vs_reg;
  assign vid.ad_out     = ad_reg;
  assign vid.nf_out     = nf_reg;
  assign vid.fc_out     = fc_reg;

  // Delay line lets TMDS control periods line up with the render pipeline latency.
  generate
    if (PIPE_DELAY == 0) begin : g_pass
      assign vid.hs_d_out = hs_reg;
      assign vid.vs_d_out = vs_reg;
      assign vid.ad_d_out = ad_reg;
    end else begin : g_pipe
      logic [PIPE_DELAY-1:0] hs_pipe_reg, hs_pipe_next;
      logic [PIPE_DELAY-1:0] vs_pipe_reg, vs_pipe_next;
      logic [PIPE_DELAY-1:0] ad_pipe_reg, ad_pipe_next;

      for (genvar gi = 0; gi < PIPE_DELAY; gi++) begin : g_stage
        if (gi == 0) begin : g_head
          assign hs_pipe_next[gi] = hs_reg;
          assign vs_pipe_next[gi] = vs_reg;
          assign ad_pipe_next[gi] = ad_reg;
        end else begin : g_body
          assign hs_pipe_next[gi] = hs_pipe_reg[gi-1];
          assign vs_pipe_next[gi] = vs_pipe_reg[gi-1];
          assign ad_pipe_next[gi] = ad_pipe_reg[gi-1];
        end
      end

      always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
          hs_pipe_reg <= {PIPE_DELAY{~SYNC_ON}};
          vs_pipe_reg <= {PIPE_DELAY{~SYNC_ON}};
          ad_pipe_reg <= '0;
        end else if (vid.en_in) begin
          hs_pipe_reg <= hs_pipe_next;
          vs_pipe_reg <= vs_pipe_next;
          ad_pipe_reg <= ad_pipe_next;
        end
      end

      assign vid.hs_d_out = hs_pipe_reg[PIPE_DELAY-1];
      assign vid.vs_d_out = vs_pipe_reg[PIPE_DELAY-1];
      assign vid.ad_d_out = ad_pipe_reg[PIPE_DELAY-1];
    end
  endgenerate

`ifdef VIDEO_TIMING_GEN_LINE_PULSE_EN
  logic          nl_reg, nl_next;
  logic [VW-1:0] line_idx_reg;

  // First blanking pixel of an active line: the line buffer may now swap.
  always_comb begin
    nl_next = (hn_ext == H_ACT) && (vn_ext < V_ACT);
  end

  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      nl_reg       <= 1'b0;
      line_idx_reg <= '0;
    end else if (vid.en_in) begin
      nl_reg <= nl_next;
      if (nl_next) begin
        line_idx_reg <= v_next;
      end
    end
  end

  assign vid.nl_out       = nl_reg;
  assign vid.line_idx_out = line_idx_reg;
`endif

endmodule
